// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline register with a 2-entry skid buffer, registered in_ready,
// programmable bubble payload and synchronous flush. Optional perf counters: PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_buf #(
   parameter int                 DATA_W     = 32,
   parameter logic [DATA_W-1:0]  BUBBLE_VAL = {DATA_W{1'b0}},
   parameter int                 CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_CNT_EN
   ,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
   logic              in_ready_q, out_valid_q;
   logic              accept, drain;

   assign accept    = in_valid & in_ready_q;
   assign drain     = out_valid_q & out_ready;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;

   // Handshake flags are re-registered from next state so neither is a decode of out_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_q      <= BUBBLE_VAL;
         skid_q      <= BUBBLE_VAL;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= (state_d != FULL);
         out_valid_q <= (state_d != EMPTY);
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               main_d  = in_data;
            end
         end
         ONE: begin
            if (accept && drain) begin
               main_d  = in_data;
            end else if (accept) begin
               state_d = FULL;
               skid_d  = in_data;
            end else if (drain) begin
               state_d = EMPTY;
               main_d  = BUBBLE_VAL;
            end
         end
         FULL: begin
            if (drain) begin
               state_d = ONE;
               main_d  = skid_q;
               skid_d  = BUBBLE_VAL;
            end
         end
         default: begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
         end
      endcase
      // Flush wins over any load; a coincident drain was already consumed downstream.
      if (flush) begin
         state_d = EMPTY;
         main_d  = BUBBLE_VAL;
         skid_d  = BUBBLE_VAL;
      end
   end

`ifdef PIPE_STAGE_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (out_valid_q && !out_ready && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (!out_valid_q && out_ready && !(&bubble_cnt))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end
`else
   // Counters compiled out; datapath is unchanged.
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: FIFO scoreboard on the output handshake
// plus directed timing checks for skid, flush, bubble, reset and counters.
module tb_pipe_stage_buf;
   localparam int             DW = 32;
   localparam logic [DW-1:0]  BV = 32'hDEADBEEF;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_CNT_EN
   logic          cnt_clr;
   logic [3:0]    stall_cnt, bubble_cnt;
`endif

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] exp_d;

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(DW), .BUBBLE_VAL(BV), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_CNT_EN
      , .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   // Scoreboard: inputs only change at posedge+1, so negedge sees what the next edge sees.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL sb_extra got=%h expected=<none>", out_data);
            end else begin
               exp_d = sb_q.pop_front();
               if (out_data !== exp_d) begin
                  n_bad++;
                  $display("FAIL sb_data got=%h expected=%h", out_data, exp_d);
               end
            end
         end
         if (flush) sb_q.delete();
         else if (in_valid && in_ready) sb_q.push_back(in_data);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef PIPE_STAGE_PERF_CNT_EN
      cnt_clr = 1'b0;
`endif
      step(); step();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== BV) begin
         n_bad++;
         $display("FAIL reset_state got=v%b r%b d%h expected=v0 r1 d%h", out_valid, in_ready, out_data, BV);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 32'h10 + i;
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== 32'h10 + i || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stream_%0d got=v%b r%b d%h expected=v1 r1 d%h", i, out_valid, in_ready, out_data, 32'h10 + i);
         end
      end
      in_valid = 1'b0;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== BV) begin
         n_bad++;
         $display("FAIL stream_end got=v%b d%h expected=v0 d%h", out_valid, out_data, BV);
      end
   endtask

   task automatic test_skid();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA1;
      step();
      in_data = 32'hA2;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA1) begin
            n_bad++;
            $display("FAIL skid_full_%0d got=r%b v%b d%h expected=r0 v1 d000000a1", i, in_ready, out_valid, out_data);
         end
         step();
      end
      out_ready = 1'b1;
      step();
      n_cmp++;
      if (in_ready !== 1'b1 || out_data !== 32'hA2) begin
         n_bad++;
         $display("FAIL skid_drain1 got=r%b d%h expected=r1 d000000a2", in_ready, out_data);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL skid_drain2 got=v%b expected=v0", out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hB1;
      step();
      in_data = 32'hB2;
      step();
      flush = 1'b1; in_data = 32'hB3;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== BV || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_state got=v%b r%b d%h expected=v0 r1 d%h", out_valid, in_ready, out_data, BV);
      end
      step(); step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_leak got=v%b d%h expected=v0", out_valid, out_data);
      end
   endtask

   task automatic test_bubble();
      n_cmp++;
      if (out_data !== BV) begin
         n_bad++;
         $display("FAIL bubble_idle got=%h expected=%h", out_data, BV);
      end
      in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'h5) begin
         n_bad++;
         $display("FAIL bubble_load got=v%b d%h expected=v1 d00000005", out_valid, out_data);
      end
      step();
      n_cmp++;
      if (out_data !== BV) begin
         n_bad++;
         $display("FAIL bubble_return got=%h expected=%h", out_data, BV);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC1;
      step();
      in_data = 32'hC2;
      step();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== BV) begin
         n_bad++;
         $display("FAIL async_reset got=v%b r%b d%h expected=v0 r1 d%h", out_valid, in_ready, out_data, BV);
      end
      sb_q.delete();
      step();
      rst = 1'b0;
      step();
      in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'h77) begin
         n_bad++;
         $display("FAIL post_reset got=v%b d%h expected=v1 d00000077", out_valid, out_data);
      end
      step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         in_data   = $urandom;
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step(); step(); step();
      n_cmp++;
      if (sb_q.size() != 0 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL random_drain got=left%0d v%b expected=left0 v0", sb_q.size(), out_valid);
      end
   endtask

`ifdef PIPE_STAGE_PERF_CNT_EN
   task automatic test_perf_cnt();
      in_valid = 1'b1; in_data = 32'h33; out_ready = 1'b0; cnt_clr = 1'b1;
      step();
      in_valid = 1'b0; cnt_clr = 1'b0;
      repeat (20) step();
      n_cmp++;
      if (stall_cnt !== 4'hF || bubble_cnt !== 4'h0) begin
         n_bad++;
         $display("FAIL stall_sat got=s%h b%h expected=sF b0", stall_cnt, bubble_cnt);
      end
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      n_cmp++;
      if (stall_cnt !== 4'h0 || bubble_cnt !== 4'h0) begin
         n_bad++;
         $display("FAIL cnt_clr got=s%h b%h expected=s0 b0", stall_cnt, bubble_cnt);
      end
      out_ready = 1'b1;
      step();
      repeat (3) step();
      n_cmp++;
      if (bubble_cnt !== 4'h3) begin
         n_bad++;
         $display("FAIL bubble_cnt got=%h expected=3", bubble_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_skid();
      test_flush();
      test_bubble();
      test_async_reset();
      test_random();
`ifdef PIPE_STAGE_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
